// File: rtl/usb_crc_pkg.sv
// Shared types for the CRC5 transmit path.
// Contents:
//   state_e       - scheduler FSM states (IDLE, LOAD, BUSY, GAP)
//   owner_e       - packet source that owns the encoder (OWN_TOK, OWN_DATA)
//   PKT_W_DEFAULT - default packet vector width, matches the encoder input
package usb_crc_pkg;

    localparam int unsigned PKT_W_DEFAULT = 100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2,
        GAP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_TOK  = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

endpackage

// File: rtl/crc_rr_arbiter2.sv
// Two-way round-robin arbiter.
// Ports:
//   clock   - clock, state on posedge
//   reset_n - asynchronous active-low reset
//   req     - request vector, index 0 = token source, index 1 = data source
//   update  - advance the pointer to the current grant
//   grant   - one-hot grant, combinational from req and the pointer
module crc_rr_arbiter2 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    // Index granted most recently. Resetting it to 1 makes index 0 win the first tie.
    logic last_q;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else if (update && (|grant)) begin
            last_q <= grant[1];
        end
    end

endmodule

// File: rtl/crc_tx_scheduler.sv
// Shares one CRC5 transmit encoder between the token source and the data source.
// Ports:
//   clock, reset_n          - clock (posedge) and asynchronous active-low reset
//   tok_req/tok_pkt/tok_len - token source request, packet and length in bits
//   data_req/data_pkt/...   - data source request, packet and length in bits
//   tok_ack, data_ack       - combinational accept pulse, packet captured at the edge
//   tok_done, data_done     - registered pulse, encoder finished that owner's packet
//   err_len                 - combinational pulse with the ack when the length is invalid
//   err_timeout             - registered pulse, encoder never reported done
//   enc_pkt_ready           - one-cycle launch pulse to the encoder
//   enc_pkt_in, enc_pkt_len - captured packet and length, held until the next capture
//   enc_done                - encoder pulse, last CRC bit accepted downstream
module crc_tx_scheduler
    import usb_crc_pkg::*;
#(
    parameter int unsigned PKT_W      = PKT_W_DEFAULT,
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             tok_req,
    input  logic [PKT_W-1:0] tok_pkt,
    input  logic [31:0]      tok_len,
    input  logic             data_req,
    input  logic [PKT_W-1:0] data_pkt,
    input  logic [31:0]      data_len,
    output logic             tok_ack,
    output logic             data_ack,
    output logic             tok_done,
    output logic             data_done,
    output logic             err_len,
    output logic             err_timeout,
    output logic             enc_pkt_ready,
    output logic [PKT_W-1:0] enc_pkt_in,
    output logic [31:0]      enc_pkt_len,
    input  logic             enc_done
);

    localparam int unsigned WD_W  = $clog2(TIMEOUT);
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e           state_q, state_d;
    owner_e           owner_q;
    logic [PKT_W-1:0] pkt_q;
    logic [31:0]      len_q;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             tok_done_q, data_done_q, err_timeout_q;

    logic [1:0]  arb_req;
    logic [1:0]  grant;
    logic        granted;
    logic [31:0] sel_len;
    logic        len_ok;
    logic        finish_ok;
    logic        finish_to;

    // Arbitrate only in IDLE; the reset_n term keeps the combinational acks low
    // while reset is held, so every output reads 0 during reset.
    assign arb_req = (state_q == IDLE && reset_n) ? {data_req, tok_req} : 2'b00;

    crc_rr_arbiter2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (arb_req),
        .update  (granted),
        .grant   (grant)
    );

    assign granted = |grant;
    assign sel_len = grant[1] ? data_len : tok_len;
    assign len_ok  = (sel_len != 32'd0) && (sel_len <= 32'(PKT_W));

    assign tok_ack       = grant[0];
    assign data_ack      = grant[1];
    assign err_len       = granted && !len_ok;
    assign enc_pkt_ready = (state_q == LOAD);
    assign enc_pkt_in    = pkt_q;
    assign enc_pkt_len   = len_q;
    assign tok_done      = tok_done_q;
    assign data_done     = data_done_q;
    assign err_timeout   = err_timeout_q;

    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        gap_d     = gap_q;
        finish_ok = 1'b0;
        finish_to = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (granted && len_ok) state_d = LOAD;
            end
            LOAD: begin
                state_d = BUSY;
                wd_d    = '0;
            end
            BUSY: begin
                wd_d = wd_q + 1'b1;
                // enc_done takes priority over the watchdog in its final cycle
                if (enc_done) begin
                    finish_ok = 1'b1;
                end else if (wd_q == WD_LAST) begin
                    finish_to = 1'b1;
                end
                if (finish_ok || finish_to) begin
                    gap_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            owner_q       <= OWN_TOK;
            pkt_q         <= '0;
            len_q         <= '0;
            wd_q          <= '0;
            gap_q         <= '0;
            tok_done_q    <= 1'b0;
            data_done_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wd_q          <= wd_d;
            gap_q         <= gap_d;
            tok_done_q    <= finish_ok && (owner_q == OWN_TOK);
            data_done_q   <= finish_ok && (owner_q == OWN_DATA);
            err_timeout_q <= finish_to;
            // Every grant is captured, including ones rejected for length.
            if (granted) begin
                pkt_q   <= grant[1] ? data_pkt : tok_pkt;
                len_q   <= sel_len;
                owner_q <= grant[1] ? OWN_DATA : OWN_TOK;
            end
        end
    end

endmodule

// File: tb/tb_crc_tx_scheduler.sv
module tb_crc_tx_scheduler;

    localparam int unsigned PKT_W      = 100;
    localparam int unsigned TIMEOUT    = 32;
    localparam int unsigned GAP_CYCLES = 2;

    localparam int K_TACK  = 0;
    localparam int K_DACK  = 1;
    localparam int K_ELEN  = 2;
    localparam int K_RDY   = 3;
    localparam int K_TDONE = 4;
    localparam int K_DDONE = 5;
    localparam int K_ETO   = 6;

    typedef struct {
        int               cyc;
        int               kind;
        logic [PKT_W-1:0] pkt;
        logic [31:0]      len;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;

    logic             clock    = 1'b0;
    logic             reset_n  = 1'b0;
    logic             tok_req  = 1'b0;
    logic [PKT_W-1:0] tok_pkt  = '0;
    logic [31:0]      tok_len  = '0;
    logic             data_req = 1'b0;
    logic [PKT_W-1:0] data_pkt = '0;
    logic [31:0]      data_len = '0;
    logic             enc_done = 1'b0;
    logic             tok_ack, data_ack, tok_done, data_done;
    logic             err_len, err_timeout, enc_pkt_ready;
    logic [PKT_W-1:0] enc_pkt_in;
    logic [31:0]      enc_pkt_len;

    // Reference model state: when the scheduler is next free, the pending
    // encoder-done cycle, the busy window and which source won the last grant.
    int idle_from  = 0;
    int done_cyc   = -1;
    int busy_lo    = -1;
    int busy_hi    = -1;
    bit last_data  = 1'b1;

    crc_tx_scheduler #(
        .PKT_W      (PKT_W),
        .TIMEOUT    (TIMEOUT),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .tok_req       (tok_req),
        .tok_pkt       (tok_pkt),
        .tok_len       (tok_len),
        .data_req      (data_req),
        .data_pkt      (data_pkt),
        .data_len      (data_len),
        .tok_ack       (tok_ack),
        .data_ack      (data_ack),
        .tok_done      (tok_done),
        .data_done     (data_done),
        .err_len       (err_len),
        .err_timeout   (err_timeout),
        .enc_pkt_ready (enc_pkt_ready),
        .enc_pkt_in    (enc_pkt_in),
        .enc_pkt_len   (enc_pkt_len),
        .enc_done      (enc_done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [PKT_W-1:0] rand_pkt();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[PKT_W-1:0];
    endfunction

    function automatic logic [31:0] rand_len();
        case ($urandom_range(0, 9))
            0:       return 32'd0;
            1:       return 32'(PKT_W + 1);
            2:       return 32'hFFFF_FFFF;
            3:       return 32'(PKT_W);
            4:       return 32'd1;
            default: return 32'($urandom_range(1, PKT_W));
        endcase
    endfunction

    function automatic void push_ev(input int c, input int k, input logic [PKT_W-1:0] p,
                                    input logic [31:0] l);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.pkt  = p;
        e.len  = l;
        exp_q.push_back(e);
    endfunction

    // Advance one cycle; act as the encoder, with stray enc_done pulses outside BUSY.
    task automatic step();
        @(posedge clock);
        #1;
        if (cyc == done_cyc)                       enc_done = 1'b1;
        else if (cyc >= busy_lo && cyc <= busy_hi) enc_done = 1'b0;
        else                                       enc_done = ($urandom_range(0, 3) == 0);
    endtask

    task automatic raise_tok(input int len_f);
        tok_req = 1'b1;
        tok_pkt = rand_pkt();
        tok_len = (len_f >= 0) ? 32'(len_f) : rand_len();
    endtask

    task automatic raise_data(input int len_f);
        data_req = 1'b1;
        data_pkt = rand_pkt();
        data_len = (len_f >= 0) ? 32'(len_f) : rand_len();
    endtask

    // One grant. src_f: -1 random, 0 token, 1 data, 2 both. len_f/delay_f: -1 random.
    // delay_f is cycles from the first BUSY cycle to enc_done; >= TIMEOUT means never.
    task automatic do_txn(input int src_f, input int len_f, input int delay_f);
        int               raise_at;
        int               span;
        int               n;
        int               d;
        int               m;
        bit               raised;
        bit               win_data;
        logic [PKT_W-1:0] wp;
        logic [31:0]      wl;
        span     = (idle_from > cyc) ? idle_from - cyc + 2 : 2;
        raise_at = (src_f >= 0) ? cyc : cyc + int'($urandom_range(0, span));
        raised   = 1'b0;
        forever begin
            if (!raised && cyc >= raise_at) begin
                raised = 1'b1;
                if (src_f < 0) begin
                    if (!tok_req && $urandom_range(0, 1) == 1) raise_tok(len_f);
                    if (!data_req && $urandom_range(0, 1) == 1) raise_data(len_f);
                    if (!tok_req && !data_req) begin
                        if ($urandom_range(0, 1) == 1) raise_tok(len_f);
                        else                           raise_data(len_f);
                    end
                end else begin
                    if ((src_f == 0 || src_f == 2) && !tok_req)  raise_tok(len_f);
                    if ((src_f == 1 || src_f == 2) && !data_req) raise_data(len_f);
                end
            end
            if (cyc >= idle_from && (tok_req || data_req)) break;
            step();
        end
        n = cyc;
        if (tok_req && data_req) win_data = !last_data;
        else                     win_data = data_req;
        last_data = win_data;
        wp = win_data ? data_pkt : tok_pkt;
        wl = win_data ? data_len : tok_len;
        push_ev(n, win_data ? K_DACK : K_TACK, '0, '0);
        if (wl == 32'd0 || wl > PKT_W) begin
            push_ev(n, K_ELEN, '0, '0);
            idle_from = n + 1;
        end else begin
            push_ev(n + 1, K_RDY, wp, wl);
            if (delay_f >= 0) begin
                d = delay_f;
            end else begin
                case ($urandom_range(0, 7))
                    0:       d = 0;
                    1:       d = TIMEOUT - 1;
                    2:       d = TIMEOUT;
                    default: d = int'($urandom_range(0, 12));
                endcase
            end
            busy_lo = n + 2;
            if (d < TIMEOUT) begin
                m         = n + 2 + d;
                done_cyc  = m;
                busy_hi   = m;
                push_ev(m + 1, win_data ? K_DDONE : K_TDONE, '0, '0);
                idle_from = m + 1 + GAP_CYCLES;
            end else begin
                done_cyc  = -1;
                busy_hi   = n + TIMEOUT + 1;
                push_ev(n + TIMEOUT + 2, K_ETO, '0, '0);
                idle_from = n + TIMEOUT + 2 + GAP_CYCLES;
            end
        end
        step();
        if (win_data) data_req = 1'b0;
        else          tok_req  = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({tok_ack, data_ack, tok_done, data_done, err_len, err_timeout, enc_pkt_ready} !== 7'd0
            || enc_pkt_in !== '0 || enc_pkt_len !== 32'd0) begin
            failures++;
            $display("FAIL %s: outputs acks/dones/errs/ready=%b pkt=%h len=%0d, required all 0",
                     name, {tok_ack, data_ack, tok_done, data_done, err_len, err_timeout,
                     enc_pkt_ready}, enc_pkt_in, enc_pkt_len);
        end
    endtask

    // Monitor: every asserted pulse must match the head of the expected queue.
    logic [6:0] obs;
    int         ek;
    int         ec;
    always @(negedge clock) begin
        if (reset_n) begin
            obs = {err_timeout, data_done, tok_done, enc_pkt_ready, err_len, data_ack, tok_ack};
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_event: kind=%0d due at cycle %0d never seen (now %0d)",
                         exp_q[0].kind, exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            for (int k = 0; k < 7; k++) begin
                if (obs[k]) begin
                    checks++;
                    ek = (exp_q.size() > 0) ? exp_q[0].kind : -1;
                    ec = (exp_q.size() > 0) ? exp_q[0].cyc : -1;
                    if (ek != k || ec != cyc) begin
                        failures++;
                        $display("FAIL unexpected_event: got kind=%0d at cycle %0d, required kind=%0d at cycle %0d",
                                 k, cyc, ek, ec);
                    end else begin
                        if (k == K_RDY && (enc_pkt_in !== exp_q[0].pkt
                                           || enc_pkt_len !== exp_q[0].len)) begin
                            failures++;
                            $display("FAIL launch_capture: got pkt=%h len=%0d, required pkt=%h len=%0d",
                                     enc_pkt_in, enc_pkt_len, exp_q[0].pkt, exp_q[0].len);
                        end
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL tb_time_limit: simulation still running, required finish");
        $fatal(1, "time limit");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset_state");
        reset_n   = 1'b1;
        idle_from = cyc;

        // Single token, length 19, enc_done 24 cycles after launch.
        do_txn(0, 19, 23);
        // Both sources held: grants must alternate.
        for (int i = 0; i < 4; i++) do_txn(2, 50, -1);
        tok_req  = 1'b0;
        data_req = 1'b0;
        // Invalid lengths on the data source.
        do_txn(1, 0, -1);
        do_txn(1, 101, -1);
        // Watchdog expiry, then a fresh request must still be accepted.
        do_txn(0, 10, TIMEOUT);
        do_txn(1, 10, 5);
        // enc_done in the final watchdog cycle wins.
        do_txn(0, 10, TIMEOUT - 1);
        do_txn(1, int'(PKT_W), 0);

        for (int i = 0; i < 200; i++) do_txn(-1, -1, -1);
        tok_req  = 1'b0;
        data_req = 1'b0;

        // Reset in the middle of BUSY; last grant is token so data would win a tie.
        do_txn(0, 40, TIMEOUT - 1);
        repeat (5) step();
        raise_tok(30);
        raise_data(31);
        reset_n  = 1'b0;
        enc_done = 1'b0;
        #1;
        check_all_zero("reset_mid_busy");
        exp_q.delete();
        done_cyc  = -1;
        busy_lo   = -1;
        busy_hi   = -1;
        last_data = 1'b1;
        repeat (2) step();
        reset_n   = 1'b1;
        idle_from = cyc;
        do_txn(2, 20, 3);
        do_txn(2, 20, 3);
        tok_req  = 1'b0;
        data_req = 1'b0;

        while (cyc < idle_from + 6) step();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_queue: %0d expected events left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
